// File: rtl/rosc_meas_pkg.sv
// Shared types and defaults for the ring-oscillator measurement sequencer.
package rosc_meas_pkg;

    localparam int RESULT_W          = 32;
    localparam int DEF_WINDOW_W      = 16;
    localparam int DEF_HOLD_CYCLES   = 4;
    localparam int DEF_SETTLE_CYCLES = 8;
    localparam int DEF_MAX_RETRIES   = 4;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_START,
        ST_RUN,
        ST_STOP,
        ST_SETTLE,
        ST_SAMP_A,
        ST_SAMP_B,
        ST_DONE
    } state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rosc_stable_sampler.sv
// Compare-and-retry capture of the resynchronised timer count.
// kick_i marks the first sample of a pair; the cycle after it is the check.
module rosc_stable_sampler
    import rosc_meas_pkg::*;
#(
    parameter int MAX_RETRIES = DEF_MAX_RETRIES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_i,
    input  logic                kick_i,
    input  logic [RESULT_W-1:0] tmr_q_i,
    output logic [RESULT_W-1:0] value_o,
    output logic                ok_o,
    output logic                fail_o
);

    localparam int RW = $clog2(MAX_RETRIES) + 1;

    logic [RESULT_W-1:0] s0_q;
    logic                check_q;
    logic [RW-1:0]       retry_q;
    logic                match;
    logic                last_try;

    assign match    = (tmr_q_i == s0_q);
    assign last_try = (retry_q == RW'(MAX_RETRIES - 1));
    assign value_o  = tmr_q_i;
    assign ok_o     = check_q & match;
    assign fail_o   = check_q & ~match & last_try;

    // Check phase follows each kick; retry counter advances on a non-final mismatch.
    always_ff @(posedge clk) begin
        if (rst) begin
            check_q <= 1'b0;
            retry_q <= '0;
        end else begin
            check_q <= kick_i;
            if (clr_i)
                retry_q <= '0;
            else if (check_q && !match && !last_try)
                retry_q <= retry_q + 1'b1;
        end
    end

    // First sample of the pair.
    always_ff @(posedge clk) begin
        if (kick_i)
            s0_q <= tmr_q_i;
    end

endmodule

// File: rtl/rosc_measure_ctrl.sv
// Sequencer around the ring-oscillator timer: clear/start/stop pulses,
// timed measurement window, and stable capture of the elapsed count.
module rosc_measure_ctrl
    import rosc_meas_pkg::*;
#(
    parameter int WINDOW_W      = DEF_WINDOW_W,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_go,
    input  logic                cmd_abort,
    input  logic [WINDOW_W-1:0] window,
    input  logic [1:0]          byte_sel,
    output logic                busy,
    output logic                done,
    output logic                result_valid,
    output logic                error,
    output logic [RESULT_W-1:0] result,
    output logic [7:0]          data_out,
    output logic                tmr_clear,
    output logic                tmr_start,
    output logic                tmr_stop,
    input  logic [RESULT_W-1:0] tmr_count
);

    localparam int CNT_W = $clog2(max2(HOLD_CYCLES, SETTLE_CYCLES)) + 1;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, hold_val;
    logic [WINDOW_W-1:0] win_q, run_cnt_q;
    logic [RESULT_W-1:0] tmr_q, result_q, samp_value;
    logic                hold_load, run_load, accept, abort_hit, res_load, err_set;
    logic                samp_ok, samp_fail;
    logic                busy_q, done_q, valid_q, error_q;
    logic                clear_q, start_q, stop_q;

    rosc_stable_sampler #(
        .MAX_RETRIES(MAX_RETRIES)
    ) u_sampler (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (accept),
        .kick_i  (state_q == ST_SAMP_A),
        .tmr_q_i (tmr_q),
        .value_o (samp_value),
        .ok_o    (samp_ok),
        .fail_o  (samp_fail)
    );

    // Count from the oscillator domain is registered once; nothing else sees tmr_count.
    always_ff @(posedge clk) begin
        tmr_q <= tmr_count;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic; abort overrides everything outside IDLE/DONE.
    always_comb begin
        state_d   = state_q;
        hold_load = 1'b0;
        hold_val  = '0;
        run_load  = 1'b0;
        accept    = 1'b0;
        abort_hit = 1'b0;
        res_load  = 1'b0;
        err_set   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_go && !cmd_abort) begin
                    state_d   = ST_CLEAR;
                    accept    = 1'b1;
                    hold_load = 1'b1;
                    hold_val  = CNT_W'(HOLD_CYCLES - 1);
                end
            end
            ST_CLEAR: begin
                if (cnt_q == '0) begin
                    state_d   = ST_START;
                    hold_load = 1'b1;
                    hold_val  = CNT_W'(HOLD_CYCLES - 1);
                end
            end
            ST_START: begin
                if (cnt_q == '0) begin
                    state_d  = ST_RUN;
                    run_load = 1'b1;
                end
            end
            ST_RUN: begin
                if (run_cnt_q == '0) begin
                    state_d   = ST_STOP;
                    hold_load = 1'b1;
                    hold_val  = CNT_W'(HOLD_CYCLES - 1);
                end
            end
            ST_STOP: begin
                if (cnt_q == '0) begin
                    state_d   = ST_SETTLE;
                    hold_load = 1'b1;
                    hold_val  = CNT_W'(SETTLE_CYCLES - 1);
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0)
                    state_d = ST_SAMP_A;
            end
            ST_SAMP_A: state_d = ST_SAMP_B;
            ST_SAMP_B: begin
                if (samp_ok) begin
                    state_d  = ST_DONE;
                    res_load = 1'b1;
                end else if (samp_fail) begin
                    state_d  = ST_DONE;
                    res_load = 1'b1;
                    err_set  = 1'b1;
                end else begin
                    state_d = ST_SAMP_A;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (cmd_abort && state_q != ST_IDLE && state_q != ST_DONE) begin
            state_d   = ST_IDLE;
            abort_hit = 1'b1;
            hold_load = 1'b0;
            run_load  = 1'b0;
            res_load  = 1'b0;
            err_set   = 1'b0;
        end
    end

    // Counters, status flags and timer controls, all registered from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            run_cnt_q <= '0;
            win_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
            result_q  <= '0;
            clear_q   <= 1'b0;
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
        end else begin
            if (hold_load)
                cnt_q <= hold_val;
            else if (cnt_q != '0)
                cnt_q <= cnt_q - 1'b1;
            if (run_load)
                run_cnt_q <= win_q - WINDOW_W'(1);
            else if (run_cnt_q != '0)
                run_cnt_q <= run_cnt_q - 1'b1;
            if (accept)
                win_q <= (window == '0) ? WINDOW_W'(1) : window;
            if (accept || abort_hit)
                valid_q <= 1'b0;
            else if (state_d == ST_DONE)
                valid_q <= 1'b1;
            if (accept)
                error_q <= 1'b0;
            else if (err_set)
                error_q <= 1'b1;
            if (res_load)
                result_q <= samp_value;
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_DONE);
            clear_q <= (state_d == ST_CLEAR);
            start_q <= (state_d == ST_START);
            stop_q  <= (state_d == ST_STOP);
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign result_valid = valid_q;
    assign error        = error_q;
    assign result       = result_q;
    assign tmr_clear    = clear_q;
    assign tmr_start    = start_q;
    assign tmr_stop     = stop_q;
    assign data_out     = result_q[{byte_sel, 3'b000} +: 8];

endmodule
